// File: rtl/sfpcie_tgt_apb_bridge_pkg.sv
// rtl/sfpcie_tgt_apb_bridge_pkg.sv - SFPCIe package: HAL target request/completion types, APB bridge states
package SFPCIe;

  localparam int APB_ADDR_WIDTH  = 16;
  localparam int APB_TIMEOUT_DEF = 256;
  localparam int HAL_BLEN_W      = 12;

  typedef enum logic [3:0] {
    eTgtMemRd = 4'd0,
    eTgtMemWr = 4'd1,
    eTgtIORd  = 4'd2,
    eTgtIOWr  = 4'd3,
    eTgtAtom  = 4'd4,
    eTgtMsg   = 4'd5,
    eTgtMsgVD = 4'd6
  } PCIeHalTgtType;

  typedef enum logic [2:0] {
    eCplSuccess = 3'b000,
    eCplUnSup   = 3'b001,
    eCplAbort   = 3'b100
  } PCIeHalCplCode;

  typedef enum logic [1:0] {
    eBrIdle   = 2'd0,
    eBrSetup  = 2'd1,
    eBrAccess = 2'd2,
    eBrCpl    = 2'd3
  } PCIeApbBrState;

  typedef struct packed {
    logic [15:0]           _rsvd;
    logic [2:0]            attr;
    logic [2:0]            tc;
    logic [15:0]           reqid;
    logic [9:0]            tag;
    logic [HAL_BLEN_W-1:0] blen;
    PCIeHalTgtType         ttype;
    logic [63:0]           addr;
  } PCIeHalTgtReq;

  typedef struct packed {
    logic [51:0]           _rsvd;
    logic [7:0]            _tgtfn;
    logic                  _ecrc;
    logic                  ep;
    logic [2:0]            attr;
    PCIeHalCplCode         code;
    logic [2:0]            tc;
    logic [15:0]           reqid;
    logic [9:0]            tag;
    logic [6:0]            addr;
    logic [HAL_BLEN_W-1:0] bcount;
    logic [HAL_BLEN_W-1:0] blen;
  } PCIeHalTgtCpl;

  // Reserved/attribute fields are always zero in completions from this bridge.
  function automatic PCIeHalTgtCpl mk_cpl(input PCIeHalCplCode code,
                                          input logic [2:0] tc,
                                          input logic [9:0] tag,
                                          input logic [15:0] reqid,
                                          input logic [6:0] addr,
                                          input logic [HAL_BLEN_W-1:0] blen);
    PCIeHalTgtCpl c;
    c        = '0;
    c.code   = code;
    c.tc     = tc;
    c.tag    = tag;
    c.reqid  = reqid;
    c.addr   = addr;
    c.blen   = blen;
    c.bcount = blen;
    return c;
  endfunction

endpackage

// File: rtl/sfpcie_apb_strb.sv
// rtl/sfpcie_apb_strb.sv - byte-lane strobe and single-DW support check for a target request
module sfpcie_apb_strb
  import SFPCIe::*;
(
  input  logic [1:0]            addr_lo,
  input  logic [HAL_BLEN_W-1:0] blen,
  output logic [3:0]            strb,
  output logic                  supported
);

  logic [3:0]          mask;
  logic [HAL_BLEN_W:0] end_byte;

  always_comb begin
    mask = 4'b0000;
    case (blen)
      HAL_BLEN_W'(1): mask = 4'b0001;
      HAL_BLEN_W'(2): mask = 4'b0011;
      HAL_BLEN_W'(3): mask = 4'b0111;
      HAL_BLEN_W'(4): mask = 4'b1111;
      default:        mask = 4'b0000;
    endcase
  end

  // A request that runs past byte 3 would need a second DW, which APB cannot do in one beat.
  assign end_byte  = {{(HAL_BLEN_W-1){1'b0}}, addr_lo} + {1'b0, blen};
  assign supported = (mask != 4'b0000) && (end_byte <= (HAL_BLEN_W+1)'(4));
  assign strb      = mask << addr_lo;

endmodule

// File: rtl/sfpcie_tgt_apb_bridge.sv
// rtl/sfpcie_tgt_apb_bridge.sv - HAL target request to single APB transfer bridge
// Optional APB wait-state timeout: SFPCIE_APB_TIMEOUT_EN
module sfpcie_tgt_apb_bridge
  import SFPCIe::*;
#(
  parameter int APB_AW      = APB_ADDR_WIDTH,
  parameter int TIMEOUT_CYC = APB_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [127:0]      req_hdr,
  input  logic [31:0]       req_wdata,
  output logic              cpl_valid,
  input  logic              cpl_ready,
  output logic [127:0]      cpl_hdr,
  output logic [31:0]       cpl_data,
  output logic [APB_AW-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  output logic [3:0]        pstrb,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              apb_err
);

  localparam logic [1:0] ST_IDLE   = eBrIdle;
  localparam logic [1:0] ST_SETUP  = eBrSetup;
  localparam logic [1:0] ST_ACCESS = eBrAccess;
  localparam logic [1:0] ST_CPL    = eBrCpl;

  PCIeHalTgtReq hdr_in;
  PCIeHalTgtCpl cpl_q;
  logic [1:0]   state;
  logic [3:0]   strb_in;
  logic         len_ok;
  logic         is_rd, is_wr, go_apb, go_ur;
  logic         unused_req;

  logic [2:0]            tc_q;
  logic [9:0]            tag_q;
  logic [15:0]           reqid_q;
  logic [6:0]            caddr_q;
  logic [HAL_BLEN_W-1:0] blen_q;
  logic [31:0]           cpl_data_q;

`ifdef SFPCIE_APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  localparam int unused_tmo_cyc = TIMEOUT_CYC;
`endif

  assign hdr_in     = req_hdr;
  assign unused_req = ^req_hdr;

  sfpcie_apb_strb u_strb (
    .addr_lo   (hdr_in.addr[1:0]),
    .blen      (hdr_in.blen),
    .strb      (strb_in),
    .supported (len_ok)
  );

  // Posted requests we cannot execute are dropped; non-posted ones get UR.
  assign is_rd  = (hdr_in.ttype == eTgtMemRd);
  assign is_wr  = (hdr_in.ttype == eTgtMemWr);
  assign go_apb = (is_rd | is_wr) & len_ok;
  assign go_ur  = (is_rd & ~len_ok) | (hdr_in.ttype == eTgtIORd) |
                  (hdr_in.ttype == eTgtIOWr) | (hdr_in.ttype == eTgtAtom);

  assign cpl_hdr  = cpl_q;
  assign cpl_data = cpl_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      cpl_valid  <= 1'b0;
      cpl_q      <= '0;
      cpl_data_q <= '0;
      paddr      <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
      pstrb      <= '0;
      apb_err    <= 1'b0;
      tc_q       <= '0;
      tag_q      <= '0;
      reqid_q    <= '0;
      caddr_q    <= '0;
      blen_q     <= '0;
`ifdef SFPCIE_APB_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      apb_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            tc_q    <= hdr_in.tc;
            tag_q   <= hdr_in.tag;
            reqid_q <= hdr_in.reqid;
            caddr_q <= hdr_in.addr[6:0];
            blen_q  <= hdr_in.blen;
            if (go_apb) begin
              state     <= ST_SETUP;
              req_ready <= 1'b0;
              psel      <= 1'b1;
              penable   <= 1'b0;
              pwrite    <= is_wr;
              paddr     <= {hdr_in.addr[APB_AW-1:2], 2'b00};
              pwdata    <= req_wdata;
              pstrb     <= strb_in;
`ifdef SFPCIE_APB_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
            end else if (go_ur) begin
              state      <= ST_CPL;
              req_ready  <= 1'b0;
              cpl_valid  <= 1'b1;
              cpl_q      <= mk_cpl(eCplUnSup, hdr_in.tc, hdr_in.tag, hdr_in.reqid,
                                   hdr_in.addr[6:0], '0);
              cpl_data_q <= '0;
            end
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          penable <= 1'b1;
        end
        ST_ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            apb_err <= pslverr;
            if (pwrite) begin
              state     <= ST_IDLE;
              req_ready <= 1'b1;
            end else begin
              state      <= ST_CPL;
              cpl_valid  <= 1'b1;
              cpl_q      <= pslverr ? mk_cpl(eCplAbort, tc_q, tag_q, reqid_q, caddr_q, '0)
                                    : mk_cpl(eCplSuccess, tc_q, tag_q, reqid_q, caddr_q, blen_q);
              cpl_data_q <= pslverr ? 32'h0 : prdata;
            end
          end
`ifdef SFPCIE_APB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            apb_err <= 1'b1;
            if (pwrite) begin
              state     <= ST_IDLE;
              req_ready <= 1'b1;
            end else begin
              state      <= ST_CPL;
              cpl_valid  <= 1'b1;
              cpl_q      <= mk_cpl(eCplAbort, tc_q, tag_q, reqid_q, caddr_q, '0);
              cpl_data_q <= 32'h0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        default: begin
          if (cpl_ready) begin
            state     <= ST_IDLE;
            cpl_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfpcie_tgt_apb_bridge.sv
// tb/tb_sfpcie_tgt_apb_bridge.sv - directed vector bench for sfpcie_tgt_apb_bridge
module tb_sfpcie_tgt_apb_bridge;
  import SFPCIe::*;

`ifdef SFPCIE_APB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 256;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [127:0] req_hdr;
  logic [31:0]  req_wdata;
  logic         cpl_valid, cpl_ready;
  logic [127:0] cpl_hdr;
  logic [31:0]  cpl_data;
  logic [15:0]  paddr;
  logic         psel, penable, pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [31:0]  prdata;
  logic         pready, pslverr, apb_err;

  int n_vec = 0;
  int n_err = 0;

  sfpcie_tgt_apb_bridge #(.APB_AW(16), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_hdr(req_hdr), .req_wdata(req_wdata), .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
    .cpl_hdr(cpl_hdr), .cpl_data(cpl_data), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .apb_err(apb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    PCIeHalTgtType ttype;
    logic [63:0]   addr;
    logic [11:0]   blen;
    logic [9:0]    tag;
    logic [31:0]   wdata;
    int            waits;
    logic [31:0]   rdata;
    logic          slverr;
    logic          exp_apb;
    logic [15:0]   exp_paddr;
    logic [3:0]    exp_pstrb;
    logic          exp_pwrite;
    logic          exp_cpl;
    int            exp_cpl_cyc;
    PCIeHalCplCode exp_code;
    logic [11:0]   exp_cblen;
    logic [6:0]    exp_caddr;
    logic [31:0]   exp_data;
    int            exp_err;
    int            exp_done;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_req(input PCIeHalTgtType tt, input logic [63:0] a,
                                          input logic [11:0] bl, input logic [9:0] tg);
    PCIeHalTgtReq h;
    h       = '0;
    h.ttype = tt;
    h.addr  = a;
    h.blen  = bl;
    h.tag   = tg;
    h.reqid = 16'hBEEF;
    h.tc    = 3'd5;
    h.attr  = 3'd7;
    return h;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    PCIeHalTgtCpl c;
    logic [31:0]  cd;
    logic [15:0]  pa;
    logic [3:0]   ps;
    logic         pw, got_psel, got_cpl, stable;
    logic [31:0]  pd;
    int acc_n, first_psel, cpl_cyc, done_cyc, err_n;
    string p;
    p = $sformatf("v%0d", idx);
    c = '0; cd = '0; pa = '0; ps = '0; pw = 1'b0; pd = '0;
    chk({p, ".req_ready_pre"}, req_ready, 1'b1);
    req_hdr   = mk_req(v.ttype, v.addr, v.blen, v.tag);
    req_wdata = v.wdata;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_hdr   = '0;
    got_psel = 1'b0; got_cpl = 1'b0; stable = 1'b1;
    acc_n = 0; err_n = 0; first_psel = -1; cpl_cyc = -1; done_cyc = -1;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      pready = 1'b0; pslverr = 1'b0; prdata = '0; cpl_ready = 1'b0;
      if (apb_err) err_n++;
      if (psel && !got_psel) begin
        got_psel = 1'b1; first_psel = cyc; pa = paddr; ps = pstrb; pw = pwrite; pd = pwdata;
      end
      if (psel && (paddr !== pa || pstrb !== ps || pwrite !== pw || pwdata !== pd)) stable = 1'b0;
      if (psel && penable) begin
        acc_n++;
        if (acc_n == v.waits + 1) begin
          pready = 1'b1; pslverr = v.slverr; prdata = v.rdata;
        end
      end
      if (cpl_valid && !got_cpl) begin
        got_cpl = 1'b1; cpl_cyc = cyc; c = cpl_hdr; cd = cpl_data;
      end
      if (cpl_valid) cpl_ready = 1'b1;
      if (req_ready) done_cyc = cyc;
      if (done_cyc < 0) tick();
    end
    pready = 1'b0; pslverr = 1'b0; cpl_ready = 1'b0;
    chk({p, ".finished"}, done_cyc > 0, 1'b1);
    chk({p, ".apb_seen"}, got_psel, v.exp_apb);
    if (v.exp_apb) begin
      chk({p, ".psel_cyc"}, first_psel, 1);
      chk({p, ".paddr"}, pa, v.exp_paddr);
      chk({p, ".pstrb"}, ps, v.exp_pstrb);
      chk({p, ".pwrite"}, pw, v.exp_pwrite);
      if (v.exp_pwrite) chk({p, ".pwdata"}, pd, v.wdata);
      chk({p, ".access_cycles"}, acc_n, v.waits + 1);
      chk({p, ".apb_stable"}, stable, 1'b1);
    end
    chk({p, ".cpl_seen"}, got_cpl, v.exp_cpl);
    if (v.exp_cpl) begin
      chk({p, ".cpl_cyc"}, cpl_cyc, v.exp_cpl_cyc);
      chk({p, ".code"}, c.code, v.exp_code);
      chk({p, ".cblen"}, c.blen, v.exp_cblen);
      chk({p, ".bcount"}, c.bcount, v.exp_cblen);
      chk({p, ".tag"}, c.tag, v.tag);
      chk({p, ".reqid"}, c.reqid, 16'hBEEF);
      chk({p, ".tc"}, c.tc, 3'd5);
      chk({p, ".caddr"}, c.addr, v.exp_caddr);
      chk({p, ".zero_fields"}, {c._rsvd, c._tgtfn, c._ecrc, c.ep, c.attr}, '0);
      chk({p, ".cpl_data"}, cd, v.exp_data);
    end
    chk({p, ".apb_err_pulses"}, err_n, v.exp_err);
    chk({p, ".done_cyc"}, done_cyc, v.exp_done);
  endtask

  initial begin
    PCIeHalTgtCpl cap_h;
    logic [31:0]  cap_d;
    int           pen_n, err_n;
    logic         got;
    rst = 1'b1; req_valid = 1'b0; req_hdr = '0; req_wdata = '0; cpl_ready = 1'b0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;

    vecs[0]  = '{eTgtMemRd, 64'h1004, 12'd4, 10'd5, 32'h0, 0, 32'hDEADBEEF, 1'b0,
                 1'b1, 16'h1004, 4'hF, 1'b0, 1'b1, 3, eCplSuccess, 12'd4, 7'h04, 32'hDEADBEEF, 0, 4};
    vecs[1]  = '{eTgtMemWr, 64'h2002, 12'd2, 10'd6, 32'hABCD0000, 3, 32'h0, 1'b0,
                 1'b1, 16'h2000, 4'hC, 1'b1, 1'b0, 0, eCplSuccess, 12'd0, 7'h00, 32'h0, 0, 6};
    vecs[2]  = '{eTgtMemRd, 64'h3000, 12'd8, 10'd7, 32'h0, 0, 32'h0, 1'b0,
                 1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1, eCplUnSup, 12'd0, 7'h00, 32'h0, 0, 2};
    vecs[3]  = '{eTgtMemRd, 64'h4008, 12'd4, 10'd8, 32'h0, 1, 32'h11111111, 1'b1,
                 1'b1, 16'h4008, 4'hF, 1'b0, 1'b1, 4, eCplAbort, 12'd0, 7'h08, 32'h0, 1, 5};
    vecs[4]  = '{eTgtMemWr, 64'h5003, 12'd1, 10'd9, 32'hAA000000, 0, 32'h0, 1'b1,
                 1'b1, 16'h5000, 4'h8, 1'b1, 1'b0, 0, eCplSuccess, 12'd0, 7'h00, 32'h0, 1, 3};
    vecs[5]  = '{eTgtMemWr, 64'h6001, 12'd4, 10'd10, 32'h12121212, 0, 32'h0, 1'b0,
                 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 0, eCplSuccess, 12'd0, 7'h00, 32'h0, 0, 1};
    vecs[6]  = '{eTgtIORd, 64'h0010, 12'd4, 10'd11, 32'h0, 0, 32'h0, 1'b0,
                 1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1, eCplUnSup, 12'd0, 7'h10, 32'h0, 0, 2};
    vecs[7]  = '{eTgtMsg, 64'h0, 12'd4, 10'd12, 32'h0, 0, 32'h0, 1'b0,
                 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 0, eCplSuccess, 12'd0, 7'h00, 32'h0, 0, 1};
    vecs[8]  = '{eTgtMemRd, 64'h7001, 12'd2, 10'h3FF, 32'h0, 2, 32'h12345678, 1'b0,
                 1'b1, 16'h7000, 4'h6, 1'b0, 1'b1, 5, eCplSuccess, 12'd2, 7'h01, 32'h12345678, 0, 6};
    vecs[9]  = '{eTgtMemRd, 64'h0020, 12'd0, 10'd13, 32'h0, 0, 32'h0, 1'b0,
                 1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1, eCplUnSup, 12'd0, 7'h20, 32'h0, 0, 2};
    vecs[10] = '{eTgtAtom, 64'h0044, 12'd4, 10'd14, 32'h0, 0, 32'h0, 1'b0,
                 1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1, eCplUnSup, 12'd0, 7'h44, 32'h0, 0, 2};
    vecs[11] = '{eTgtMemWr, 64'hFFFF00000001ABCC, 12'd4, 10'd15, 32'h01020304, 0, 32'h0, 1'b0,
                 1'b1, 16'hABCC, 4'hF, 1'b1, 1'b0, 0, eCplSuccess, 12'd0, 7'h00, 32'h0, 0, 3};
    vecs[12] = '{eTgtIOWr, 64'h0008, 12'd4, 10'd16, 32'h0, 0, 32'h0, 1'b0,
                 1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1, eCplUnSup, 12'd0, 7'h08, 32'h0, 0, 2};
    vecs[13] = '{eTgtMemRd, 64'h0003, 12'd1, 10'd17, 32'h0, 0, 32'h55000000, 1'b0,
                 1'b1, 16'h0000, 4'h8, 1'b0, 1'b1, 3, eCplSuccess, 12'd1, 7'h03, 32'h55000000, 0, 4};

    tick(); tick();
    chk("rst.req_ready", req_ready, 1'b1);
    chk("rst.psel", psel, 1'b0);
    chk("rst.penable", penable, 1'b0);
    chk("rst.cpl_valid", cpl_valid, 1'b0);
    chk("rst.apb_err", apb_err, 1'b0);
    chk("rst.cpl_hdr", cpl_hdr[63:0], 64'h0);
    chk("rst.paddr_pstrb", {paddr, pstrb, pwrite}, '0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      run_vec(i, vecs[i]);
      tick();
    end

    // Completion back-pressure: fields must hold until the handshake.
    req_hdr = mk_req(eTgtMemRd, 64'h0100, 12'd4, 10'd9);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    pready = 1'b1; prdata = 32'hCAFEF00D;
    tick();
    pready = 1'b0; prdata = '0;
    chk("stall.cpl_valid0", cpl_valid, 1'b1);
    cap_h = cpl_hdr;
    cap_d = cpl_data;
    chk("stall.data", cap_d, 32'hCAFEF00D);
    chk("stall.code", cap_h.code, eCplSuccess);
    chk("stall.tag", cap_h.tag, 10'd9);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall%0d.cpl_valid", i), cpl_valid, 1'b1);
      chk($sformatf("stall%0d.hdr", i), cpl_hdr, cap_h);
      chk($sformatf("stall%0d.data", i), cpl_data, cap_d);
      chk($sformatf("stall%0d.req_ready", i), req_ready, 1'b0);
    end
    cpl_ready = 1'b1;
    tick();
    cpl_ready = 1'b0;
    chk("stall.req_ready_after", req_ready, 1'b1);
    chk("stall.cpl_valid_after", cpl_valid, 1'b0);

    // Asynchronous reset during a read's ACCESS phase.
    req_hdr = mk_req(eTgtMemRd, 64'h0200, 12'd4, 10'd20);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("arst.penable_pre", penable, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst.psel", psel, 1'b0);
    chk("arst.req_ready", req_ready, 1'b1);
    chk("arst.cpl_valid", cpl_valid, 1'b0);
    #2 rst = 1'b0;
    tick();
    chk("arst.psel_after", psel, 1'b0);
    chk("arst.req_ready_after", req_ready, 1'b1);

`ifdef SFPCIE_APB_TIMEOUT_EN
    // pready never returns: abandoned after TMO wait cycles with an abort completion.
    req_hdr = mk_req(eTgtMemRd, 64'h0300, 12'd4, 10'd21);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    pen_n = 0; err_n = 0; got = 1'b0; cap_h = '0;
    for (int cyc = 1; cyc <= 60 && !got; cyc++) begin
      if (penable) pen_n++;
      if (apb_err) err_n++;
      if (cpl_valid) begin
        got = 1'b1; cap_h = cpl_hdr; cap_d = cpl_data;
      end else begin
        tick();
      end
    end
    chk("tmo.cpl_seen", got, 1'b1);
    chk("tmo.access_cycles", pen_n, 16);
    chk("tmo.apb_err", err_n, 1);
    chk("tmo.code", cap_h.code, eCplAbort);
    chk("tmo.cblen", cap_h.blen, 12'd0);
    cpl_ready = 1'b1;
    tick();
    cpl_ready = 1'b0;
    chk("tmo.req_ready", req_ready, 1'b1);
`else
    pen_n = 0; err_n = 0; got = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sfpcie_tgt_apb_bridge.md
# sfpcie_tgt_apb_bridge

- Consumes PCIe HAL target requests (`PCIeHalTgtReq` plus one DW of write data) and executes them as single APB transfers to the on-chip register space.
- Returns `PCIeHalTgtCpl` completions for non-posted requests.
- Sits directly downstream of the HAL target-request interface and upstream of the APB register fabric; handles exactly one outstanding request.

## Interface
Parameters:
- `APB_AW`, default `SFPCIe::APB_ADDR_WIDTH` (16): APB address width.
- `TIMEOUT_CYC`, default 256: APB wait-state limit; used only with the timeout feature compiled in.

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, 1: target request valid.
- `req_ready`, out, 1: bridge accepts a request.
- `req_hdr`, in, 128: `PCIeHalTgtReq`.
- `req_wdata`, in, 32: write DW, byte lanes aligned to `addr[1:0]`.
- `cpl_valid`, out, 1: completion valid.
- `cpl_ready`, in, 1: completion accepted.
- `cpl_hdr`, out, 128: `PCIeHalTgtCpl`.
- `cpl_data`, out, 32: read data DW.
- `paddr`, out, `APB_AW`: DW-aligned address (`[1:0]`=0).
- `psel`, `penable`, `pwrite`, out, 1 each: APB control.
- `pwdata`, out, 32: APB write data.
- `pstrb`, out, 4: APB byte strobes.
- `prdata`, in, 32: APB read data.
- `pready`, `pslverr`, in, 1 each: APB response.
- `apb_err`, out, 1: one-cycle pulse on `pslverr` or timeout.

## Operation
- FSM states: IDLE, SETUP, ACCESS, CPL.
- `req_ready` = (state==IDLE); a request is accepted on `req_valid & req_ready`; header and data are registered.
- Request is supported when `ttype` ∈ {eTgtMemRd, eTgtMemWr}, 1 ≤ `blen` ≤ 4, and `addr[1:0]+blen` ≤ 4 (no DW crossing).
- Supported requests: IDLE→SETUP→ACCESS.
  - `pstrb` = contiguous `blen` ones shifted left by `addr[1:0]`.
  - `pwrite`=1 for MemWr.
  - `paddr` = {`addr[APB_AW-1:2]`, 2'b00}.
- ACCESS holds until `pready`:
  - MemWr → IDLE; no completion, since writes are posted.
  - MemRd → CPL.
- Unsupported MemRd, and any IORd, IOWr, or eTgtAtom: IDLE→CPL directly with code=eCplUnSup; no APB activity.
- Unsupported MemWr, eTgtMsg, eTgtMsgVD: dropped silently; stay IDLE.
- Completion fields:
  - `tag`, `reqid`, `tc` copied from the request.
  - `ep`=0, `attr`=0, `_ecrc`=0, `_tgtfn`=0, `_rsvd`=0.
  - `addr` = request `addr[6:0]`.
  - Success: code=eCplSuccess, `blen`=`bcount`=request `blen`, `cpl_data`=`prdata` (unshifted).
  - `pslverr` on read: code=eCplAbort, `blen`=`bcount`=0, `cpl_data`=0.
  - UR: code=eCplUnSup, `blen`=`bcount`=0.
- CPL holds `cpl_valid` and all completion fields stable until `cpl_ready`, then → IDLE.
- `pslverr` on a write: write is dropped, `apb_err` pulses, → IDLE.

## Timing
- Reset values: all outputs 0 except `req_ready`=1; state=IDLE.
- Reset mid-transfer: `psel` and `cpl_valid` drop immediately (asynchronous); the in-flight request is lost.
- Latency, with accept at cycle T:
  - `psel`=1, `penable`=0 at T+1.
  - `penable`=1 at T+2.
  - With zero wait states (`pready`@T+2), read `cpl_valid` rises at T+3.
  - After a write, `req_ready` returns at T+3.
- Each APB wait state adds one cycle. `paddr`, `pwrite`, `pwdata`, `pstrb` are stable from SETUP through the `pready` cycle.
- All outputs are registered. `psel` and `penable` fall in the cycle after `pready`.
- Unsupported non-posted request: `cpl_valid` at T+1.
- Throughput: at most one request per 3 cycles.
- `cpl_ready` held high: CPL lasts one cycle, and `req_ready` is high the cycle after.

## Configuration
- `SFPCIE_APB_TIMEOUT_EN` defined:
  - A counter increments per ACCESS cycle with `pready`=0.
  - On reaching `TIMEOUT_CYC`, the transfer is abandoned: `psel`/`penable` drop and `apb_err` pulses.
  - Read → CPL with eCplAbort; write → IDLE.
  - The counter clears on every SETUP entry.
- `SFPCIE_APB_TIMEOUT_EN` undefined: no counter logic; ACCESS waits indefinitely for `pready`.

## Structure
- Add to package `SFPCIe`:
  - `PCIeApbBrState` enum (eBrIdle, eBrSetup, eBrAccess, eBrCpl).
  - `APB_TIMEOUT_DEF` = 256.
- Sub-module `sfpcie_apb_strb`: combinational `addr[1:0]`, `blen` → `pstrb` and a `supported` flag.

## Test plan
- MemRd, `addr`=0x0000_0000_0000_1004, `blen`=4, `tag`=5, `pready` at first ACCESS, `prdata`=0xDEADBEEF:
  - `paddr`=0x1004, `pstrb`=4'hF, `psel` at T+1.
  - `cpl_valid` at T+3 with code=eCplSuccess, `blen`=4, `tag`=5, `cpl_data`=0xDEADBEEF.
- MemWr, `addr`=0x2002, `blen`=2, `req_wdata`=0xABCD0000, 3 wait states:
  - `pstrb`=4'hC, `pwdata`=0xABCD0000, `pwrite`=1.
  - No `cpl_valid`; `req_ready` returns at T+6.
- MemRd, `blen`=8 → no `psel`; `cpl_valid` at T+1 with code=eCplUnSup, `blen`=0.
- MemRd with `pslverr`=1 → code=eCplAbort, `apb_err` one pulse.
- MemRd, `cpl_ready` low for 5 cycles:
  - Completion fields stable throughout; `req_ready` stays 0 until the handshake.
  - Then assert `rst` during a second read's ACCESS: `psel`=0 and `req_ready`=1 asynchronously.
- With `SFPCIE_APB_TIMEOUT_EN`, `TIMEOUT_CYC`=16, `pready` never asserted → abandon after 16 ACCESS cycles; read completes with eCplAbort.
